muldiv_unit: RTL and testbench

Multi-cycle multiply/divide unit for MIPS MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits beside the combinational ALU in EX and performs the iterative arithmetic the ALU does not cover (shift-add multiply, restoring divide).
- Owns the architectural HI/LO registers.
- The pipeline issues an op with a start pulse, stalls on busy, and reads hi/lo for MFHI/MFLO.

---
 rtl/muldiv_unit_pkg.sv | 30 +++
 rtl/muldiv_sign_fix.sv | 13 +
 rtl/muldiv_unit.sv | 213 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared datapath constants, mult/div opcodes and FSM encodings for muldiv_unit.
package muldiv_unit_pkg;

  localparam int CPU_DP_WIDTH = 32;
  localparam int MDOP_WIDTH   = 2;

  typedef enum logic [MDOP_WIDTH-1:0] {
    MdOp_Mult  = 2'd0,
    MdOp_Multu = 2'd1,
    MdOp_Div   = 2'd2,
    MdOp_Divu  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  function automatic logic md_is_div(input logic [MDOP_WIDTH-1:0] op);
    return op[1];
  endfunction

  // Only MULT and DIV are signed; every other code behaves as its unsigned form.
  function automatic logic md_is_signed(input logic [MDOP_WIDTH-1:0] op);
    return (op == MdOp_Mult) || (op == MdOp_Div);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational conditional two's-complement negate; used for operand
// magnitudes and for applying result signs.
module muldiv_sign_fix #(
  parameter int W = 64
) (
  input  logic [W-1:0] value_i,
  input  logic         neg_i,
  output logic [W-1:0] result_o
);

  assign result_o = neg_i ? (~value_i + W'(1)) : value_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO.
// Optional MULDIV_EARLY_OUT_EN: multiplies leave CALC once the remaining multiplier bits are zero.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int DP_WIDTH  = CPU_DP_WIDTH,
  parameter int CNT_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [MDOP_WIDTH-1:0] md_op,
  input  logic [DP_WIDTH-1:0]   A,
  input  logic [DP_WIDTH-1:0]   B,
  input  logic                  hi_we,
  input  logic                  lo_we,
  input  logic [DP_WIDTH-1:0]   wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  div_zero,
  output logic [DP_WIDTH-1:0]   hi,
  output logic [DP_WIDTH-1:0]   lo
);

  md_state_e               state_q, state_d;
  md_op_e                  op_q, op_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [DP_WIDTH-1:0]     acc_hi_q, acc_hi_d;   // P for multiply, remainder for divide
  logic [DP_WIDTH-1:0]     acc_lo_q, acc_lo_d;   // M for multiply, dividend/quotient for divide
  logic [DP_WIDTH-1:0]     opnd_q, opnd_d;       // multiplicand or divisor magnitude
  logic                    neg_res_q, neg_res_d;
  logic                    neg_rem_q, neg_rem_d;
  logic [DP_WIDTH-1:0]     hi_q, hi_d;
  logic [DP_WIDTH-1:0]     lo_q, lo_d;
  logic                    div_zero_q, div_zero_d;

  logic                    sgn_op;
  logic [DP_WIDTH-1:0]     a_mag, b_mag;
  logic                    is_div_q;

  assign sgn_op   = md_is_signed(md_op);
  assign is_div_q = md_is_div(op_q);

  muldiv_sign_fix #(.W(DP_WIDTH)) u_abs_a (
    .value_i  (A),
    .neg_i    (sgn_op & A[DP_WIDTH-1]),
    .result_o (a_mag)
  );

  muldiv_sign_fix #(.W(DP_WIDTH)) u_abs_b (
    .value_i  (B),
    .neg_i    (sgn_op & B[DP_WIDTH-1]),
    .result_o (b_mag)
  );

  // One shift-add multiply step on {P,M}.
  logic [DP_WIDTH:0]   mul_sum;
  logic [DP_WIDTH-1:0] mul_hi_next, mul_lo_next;

  assign mul_sum     = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_hi_next = mul_sum[DP_WIDTH:1];
  assign mul_lo_next = {mul_sum[0], acc_lo_q[DP_WIDTH-1:1]};

  // One restoring divide step; the shifted remainder needs the extra top bit.
  logic [DP_WIDTH:0]   div_shift, div_trial;
  logic                div_ok;
  logic [DP_WIDTH-1:0] div_hi_next, div_lo_next;

  assign div_shift   = {acc_hi_q, acc_lo_q[DP_WIDTH-1]};
  assign div_trial   = div_shift - {1'b0, opnd_q};
  assign div_ok      = ~div_trial[DP_WIDTH];
  assign div_hi_next = div_ok ? div_trial[DP_WIDTH-1:0] : div_shift[DP_WIDTH-1:0];
  assign div_lo_next = {acc_lo_q[DP_WIDTH-2:0], div_ok};

  logic                    calc_last;
  logic [2*DP_WIDTH-1:0]   prod_raw, prod_aln;

  assign prod_raw = {acc_hi_q, acc_lo_q};

`ifdef MULDIV_EARLY_OUT_EN
  // After step cnt_q, the low (DP_WIDTH-1-cnt_q) bits of M are still unconsumed multiplier.
  logic [DP_WIDTH-1:0]  mul_rest_mask;
  logic [CNT_WIDTH:0]   mul_shamt;

  assign mul_rest_mask = {DP_WIDTH{1'b1}} >> (cnt_q + CNT_WIDTH'(1));
  assign calc_last     = (cnt_q == CNT_WIDTH'(DP_WIDTH - 1)) ||
                         (!is_div_q && ((mul_lo_next & mul_rest_mask) == '0));
  // An early exit leaves {P,M} short of full alignment by the skipped steps.
  assign mul_shamt     = (CNT_WIDTH + 1)'(DP_WIDTH) - {1'b0, cnt_q};
  assign prod_aln      = prod_raw >> mul_shamt;
`else
  assign calc_last = (cnt_q == CNT_WIDTH'(DP_WIDTH - 1));
  assign prod_aln  = prod_raw;
`endif

  logic [2*DP_WIDTH-1:0] fix_in, fix_res;
  logic [DP_WIDTH-1:0]   fix_rem;

  assign fix_in = is_div_q ? {{DP_WIDTH{1'b0}}, acc_lo_q} : prod_aln;

  muldiv_sign_fix #(.W(2 * DP_WIDTH)) u_fix_res (
    .value_i  (fix_in),
    .neg_i    (neg_res_q),
    .result_o (fix_res)
  );

  muldiv_sign_fix #(.W(DP_WIDTH)) u_fix_rem (
    .value_i  (acc_hi_q),
    .neg_i    (neg_rem_q),
    .result_o (fix_rem)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    opnd_d     = opnd_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;

    case (state_q)
      MD_IDLE: begin
        if (start) begin
          if (md_is_div(md_op) && (B == '0)) begin
            state_d    = MD_DONE;
            div_zero_d = 1'b1;
          end else begin
            state_d   = MD_CALC;
            op_d      = md_op_e'(md_op);
            cnt_d     = '0;
            acc_hi_d  = '0;
            neg_res_d = sgn_op & (A[DP_WIDTH-1] ^ B[DP_WIDTH-1]);
            if (md_is_div(md_op)) begin
              acc_lo_d   = a_mag;
              opnd_d     = b_mag;
              neg_rem_d  = sgn_op & A[DP_WIDTH-1];
              div_zero_d = 1'b0;
            end else begin
              acc_lo_d  = b_mag;
              opnd_d    = a_mag;
              neg_rem_d = 1'b0;
            end
          end
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end

      MD_CALC: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (is_div_q) begin
          acc_hi_d = div_hi_next;
          acc_lo_d = div_lo_next;
        end else begin
          acc_hi_d = mul_hi_next;
          acc_lo_d = mul_lo_next;
        end
        if (calc_last) state_d = MD_FIX;
      end

      MD_FIX: begin
        hi_d    = is_div_q ? fix_rem : fix_res[2*DP_WIDTH-1:DP_WIDTH];
        lo_d    = fix_res[DP_WIDTH-1:0];
        state_d = MD_DONE;
      end

      MD_DONE: state_d = MD_IDLE;

      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MD_IDLE;
      op_q       <= MdOp_Mult;
      cnt_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opnd_q     <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      opnd_q     <= opnd_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q == MD_CALC) || (state_q == MD_FIX);
  assign done     = (state_q == MD_DONE);
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; all inputs driven and outputs sampled on negedge.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] A, B, wdata;
  logic        hi_we, lo_we;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;
  int lat, bc;

  muldiv_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .md_op    (md_op),
    .A        (A),
    .B        (B),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle t+1.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int k0, output int l, output int busy_cnt);
    l = k0;
    busy_cnt = 0;
    while (!done && l < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      l++;
    end
    check({tag, ":done"}, done, 1);
    check({tag, ":busy_at_done"}, busy, 0);
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, output int l, output int busy_cnt);
    issue(op, a, b);
    wait_done(tag, 1, l, busy_cnt);
    $display("[TB] %s op=%0d A=0x%08h B=0x%08h -> hi=0x%08h lo=0x%08h lat=%0d dz=%0b",
             tag, op, a, b, hi, lo, l, div_zero);
    @(negedge clk);
    check({tag, ":done_clr"}, done, 0);
  endtask

  task automatic mt(input logic hw, input logic lw, input logic [31:0] d);
    hi_we = hw; lo_we = lw; wdata = d;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    $display("[TB] mt hi_we=%0b lo_we=%0b data=0x%08h -> hi=0x%08h lo=0x%08h", hw, lw, d, hi, lo);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; md_op = 2'd0; A = '0; B = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    check("rst:busy", busy, 0);
    check("rst:done", done, 0);
    check("rst:div_zero", div_zero, 0);
    check("rst:hi", hi, 0);
    check("rst:lo", lo, 0);
    rst = 1'b0;
    @(negedge clk);

    run("multu_max", MdOp_Multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
    check("multu_max:lat", lat, 34);
    check("multu_max:busy_cycles", bc, 33);
    check("multu_max:hi", hi, 32'hFFFF_FFFE);
    check("multu_max:lo", lo, 32'h0000_0001);

    run("mult_neg", MdOp_Mult, 32'hFFFF_FFFD, 32'd7, lat, bc);
    check("mult_neg:hi", hi, 32'hFFFF_FFFF);
    check("mult_neg:lo", lo, 32'hFFFF_FFEB);

    run("div_neg", MdOp_Div, 32'hFFFF_FFF9, 32'd2, lat, bc);
    check("div_neg:lat", lat, 34);
    check("div_neg:lo", lo, 32'hFFFF_FFFD);
    check("div_neg:hi", hi, 32'hFFFF_FFFF);

    run("divu", MdOp_Divu, 32'd100, 32'd7, lat, bc);
    check("divu:lo", lo, 32'd14);
    check("divu:hi", hi, 32'd2);

    run("div_ovf", MdOp_Div, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
    check("div_ovf:lo", lo, 32'h8000_0000);
    check("div_ovf:hi", hi, 32'h0000_0000);

    mt(1'b1, 1'b0, 32'h0000_ABCD);
    check("mthi:hi", hi, 32'h0000_ABCD);
    check("mthi:lo_kept", lo, 32'h8000_0000);
    mt(1'b1, 1'b1, 32'h0000_0077);
    check("mt_both:hi", hi, 32'h77);
    check("mt_both:lo", lo, 32'h77);
    mt(1'b1, 1'b0, 32'h11);
    mt(1'b0, 1'b1, 32'h22);
    check("mtlo:hi_kept", hi, 32'h11);
    check("mtlo:lo", lo, 32'h22);

    run("divu_zero", MdOp_Divu, 32'd5, 32'd0, lat, bc);
    check("divu_zero:lat", lat, 1);
    check("divu_zero:hi", hi, 32'h11);
    check("divu_zero:lo", lo, 32'h22);
    check("divu_zero:div_zero", div_zero, 1);

    run("multu_keep_dz", MdOp_Multu, 32'd2, 32'd3, lat, bc);
    check("multu_keep_dz:div_zero", div_zero, 1);
    check("multu_keep_dz:lo", lo, 32'd6);

    run("divu_9_3", MdOp_Divu, 32'd9, 32'd3, lat, bc);
    check("divu_9_3:div_zero", div_zero, 0);
    check("divu_9_3:lo", lo, 32'd3);
    check("divu_9_3:hi", hi, 32'd0);

    // New start and MT writes while busy must both be ignored.
    issue(MdOp_Multu, 32'd6, 32'h8000_0001);
    check("busy_ign:busy", busy, 1);
    start = 1'b1; md_op = MdOp_Divu; A = 32'd1; B = 32'd0;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check("busy_ign:hi_mid", hi, 32'd0);
    wait_done("busy_ign", 2, lat, bc);
    $display("[TB] busy_ign multu 6 x 0x80000001 -> hi=0x%08h lo=0x%08h lat=%0d", hi, lo, lat);
    check("busy_ign:lat", lat, 34);
    check("busy_ign:hi", hi, 32'd3);
    check("busy_ign:lo", lo, 32'd6);
    check("busy_ign:div_zero", div_zero, 0);
    @(negedge clk);

    // start beats a simultaneous MTHI in IDLE.
    hi_we = 1'b1; wdata = 32'h5555_5555;
    issue(MdOp_Multu, 32'd2, 32'd2);
    hi_we = 1'b0;
    check("start_wins:hi_kept", hi, 32'd3);
    wait_done("start_wins", 1, lat, bc);
    $display("[TB] start_wins multu 2 x 2 -> hi=0x%08h lo=0x%08h lat=%0d", hi, lo, lat);
    check("start_wins:hi", hi, 32'd0);
    check("start_wins:lo", lo, 32'd4);
    @(negedge clk);

    // Reset in the middle of CALC.
    issue(MdOp_Multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(negedge clk);
    check("mid_rst:busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] mid_rst -> busy=%0b hi=0x%08h lo=0x%08h", busy, hi, lo);
    check("mid_rst:busy", busy, 0);
    check("mid_rst:done", done, 0);
    check("mid_rst:hi", hi, 32'd0);
    check("mid_rst:lo", lo, 32'd0);
    @(negedge clk);
    check("mid_rst:idle_busy", busy, 0);
    run("post_rst_divu", MdOp_Divu, 32'd100, 32'd7, lat, bc);
    check("post_rst_divu:lat", lat, 34);
    check("post_rst_divu:lo", lo, 32'd14);
    check("post_rst_divu:hi", hi, 32'd2);

    run("multu_5_3", MdOp_Multu, 32'd5, 32'd3, lat, bc);
`ifdef MULDIV_EARLY_OUT_EN
    check("multu_5_3:lat_le5", (lat <= 5), 1);
`else
    check("multu_5_3:lat", lat, 34);
`endif
    check("multu_5_3:lo", lo, 32'd15);
    check("multu_5_3:hi", hi, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
